code_lock: RTL and testbench
============================

CODE_LOCK -- requirements
Module: code_lock

Interface
REQ-001 Parameter NBTN, default 4: number of one-hot keypad buttons, 2..16; digit width DW = clog2(NBTN).
REQ-002 Parameter CODE_LEN, default 4: digits per code, 1..8.
REQ-003 Parameter PASSWORD, default 0 packed as CODE_LEN*DW bits: factory code, digit i at bits [i*DW +: DW], digit 0 entered first.
REQ-004 Parameter MAX_TRIES, default 3: consecutive failed verifies before lockout, 1..15.
REQ-005 Parameter LOCKOUT_CYCLES, default 16: lockout duration in clocks, >=1.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 btn  input  NBTN  keypad buttons, one-hot when valid.
REQ-009 enter  input  1  confirm; clear  input  1  abort/relock.
REQ-010 state  output  3  current state; locked, unlocked, error, lockout  output  1 each  state decodes.
REQ-011 digit_cnt  output  clog2(CODE_LEN+1)  digits captured; fail_cnt  output  4  consecutive failures.
REQ-012 invalid  output  1  one-cycle pulse when a press event has more than one button set.

Function
REQ-013 States: LOCKED=0, INPUT=1, VERIFY=2, ERROR=3, UNLOCKED=4, LOCKOUT=5, PROGRAM=6; any other code -> LOCKED next cycle.
REQ-014 Press event: btn != 0 in this cycle and btn == 0 in the previous cycle; held buttons produce one event only.
REQ-015 Event with exactly one bit set decodes to its bit index; event with >1 bit set pulses invalid and sets internal bad flag.
REQ-016 Same-cycle priority: clear > enter > press event.
REQ-017 LOCKED: enter -> INPUT, clearing digit_cnt, bad flag and digit buffer; presses ignored.
REQ-018 INPUT: valid event with digit_cnt < CODE_LEN stores digit at position digit_cnt, digit_cnt+1; valid event at digit_cnt == CODE_LEN sets bad (overflow); clear -> LOCKED; enter -> VERIFY.
REQ-019 VERIFY lasts exactly one cycle; match = (digit_cnt == CODE_LEN) and !bad and buffer == active password.
REQ-020 VERIFY match -> UNLOCKED, fail_cnt=0; mismatch -> fail_cnt+1, then LOCKOUT if new fail_cnt == MAX_TRIES, else ERROR.
REQ-021 ERROR: clear -> LOCKED; all else ignored; fail_cnt retained.
REQ-022 UNLOCKED: clear -> LOCKED.
REQ-023 LOCKOUT: timer loaded with LOCKOUT_CYCLES-1 on entry, decrements each cycle; at 0 -> LOCKED with fail_cnt=0; btn/enter/clear ignored throughout.
REQ-024 Verify result latency: UNLOCKED/ERROR/LOCKOUT asserted two cycles after the enter that left INPUT.
REQ-025 Outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-026 reset low asynchronously forces: state=LOCKED, locked=1, unlocked=0, error=0, lockout=0, invalid=0, digit_cnt=0, fail_cnt=0, timer=0, bad=0, buffer=0, previous-btn sample=0, password register=PASSWORD.
REQ-027 Reset mid-operation (including LOCKOUT and PROGRAM) abandons all progress; lockout is not resumed.

Configuration
REQ-028 Macro CODE_LOCK_PROGRAM_EN defined: input prog (1 bit) exists; UNLOCKED with prog=1 and clear=0 -> PROGRAM with digit_cnt/bad/buffer cleared; entry as in INPUT; enter with digit_cnt == CODE_LEN and !bad writes buffer to password register and -> LOCKED; enter otherwise, or clear -> UNLOCKED, password unchanged.
REQ-029 Macro undefined: no prog port, password fixed at PASSWORD, PROGRAM unreachable and treated as illegal.

Verification (NBTN=4, CODE_LEN=4, PASSWORD digits 2,0,3,1, MAX_TRIES=3, LOCKOUT_CYCLES=16)
REQ-030 enter, press 2,0,3,1, enter -> VERIFY one cycle, then state=4, unlocked=1, fail_cnt=0; clear -> state=0.
REQ-031 enter, press 2,0,3 (3 digits), enter -> state=3, fail_cnt=1; also 5 digits 2,0,3,1,1 -> state=3 (overflow).
REQ-032 btn=4'b0101 during INPUT -> invalid pulses 1 cycle, digit_cnt unchanged, subsequent correct code -> state=3.
REQ-033 three wrong codes -> third gives state=5 for exactly 16 cycles ignoring enter/clear, then state=0, fail_cnt=0.
REQ-034 btn held 10 cycles -> one digit captured; enter and clear same cycle in INPUT -> state=0; reset low mid-LOCKOUT -> state=0 immediately.
REQ-035 With CODE_LOCK_PROGRAM_EN: unlock, prog=1, press 1,1,2,2, enter -> state=0; old code then fails, 1,1,2,2 unlocks.

Source files
------------

// File: rtl/code_lock.sv
// Keypad code lock: one-hot button capture, code verify, retry lockout.
// Optional field reprogramming of the code is enabled with `define CODE_LOCK_PROGRAM_EN.
module code_lock #(
  parameter int unsigned NBTN           = 4,
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [CODE_LEN*$clog2(NBTN)-1:0] PASSWORD = '0,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NBTN-1:0]                   btn,
  input  logic                              enter,
  input  logic                              clear,
`ifdef CODE_LOCK_PROGRAM_EN
  input  logic                              prog,
`endif
  output logic [2:0]                        state,
  output logic                              locked,
  output logic                              unlocked,
  output logic                              error,
  output logic                              lockout,
  output logic [$clog2(CODE_LEN+1)-1:0]     digit_cnt,
  output logic [3:0]                        fail_cnt,
  output logic                              invalid
);

  localparam int unsigned DW = $clog2(NBTN);
  localparam int unsigned CW = $clog2(CODE_LEN + 1);
  localparam int unsigned BW = CODE_LEN * DW;
  localparam int unsigned TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_LOCKED   = 3'd0,
    S_INPUT    = 3'd1,
    S_VERIFY   = 3'd2,
    S_ERROR    = 3'd3,
    S_UNLOCKED = 3'd4,
    S_LOCKOUT  = 3'd5,
    S_PROGRAM  = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      fail_q, fail_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [BW-1:0]   pwd_q, pwd_d;
  logic [NBTN-1:0] prev_btn;
  logic            bad_q, bad_d;
  logic            invalid_d;
  logic            press_ev, multi, accept_press, match;
  logic [DW-1:0]   digit;

  // Rising-edge press detection and one-hot decode
  always_comb begin
    press_ev = (btn != '0) && (prev_btn == '0);
    multi    = (btn & (btn - NBTN'(1))) != '0;
    digit    = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (btn[i]) digit = DW'(i);
    end
  end

  assign match = (cnt_q == CW'(CODE_LEN)) && !bad_q && (buf_q == pwd_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fail_d       = fail_q;
    timer_d      = timer_q;
    buf_d        = buf_q;
    pwd_d        = pwd_q;
    bad_d        = bad_q;
    invalid_d    = 1'b0;
    accept_press = 1'b0;
    case (state_q)
      S_LOCKED: begin
        if (!clear && enter) begin
          state_d = S_INPUT;
          cnt_d   = '0;
          bad_d   = 1'b0;
          buf_d   = '0;
        end
      end
      S_INPUT: begin
        if (clear)      state_d = S_LOCKED;
        else if (enter) state_d = S_VERIFY;
        else            accept_press = 1'b1;
      end
      S_VERIFY: begin
        if (match) begin
          state_d = S_UNLOCKED;
          fail_d  = '0;
        end else begin
          fail_d = fail_q + 4'd1;
          if (fail_d == 4'(MAX_TRIES)) begin
            state_d = S_LOCKOUT;
            timer_d = TW'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_ERROR: begin
        if (clear) state_d = S_LOCKED;
      end
      S_UNLOCKED: begin
        if (clear) state_d = S_LOCKED;
`ifdef CODE_LOCK_PROGRAM_EN
        else if (prog) begin
          state_d = S_PROGRAM;
          cnt_d   = '0;
          bad_d   = 1'b0;
          buf_d   = '0;
        end
`endif
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = S_LOCKED;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
`ifdef CODE_LOCK_PROGRAM_EN
      S_PROGRAM: begin
        if (clear) begin
          state_d = S_UNLOCKED;
        end else if (enter) begin
          state_d = S_UNLOCKED;
          if ((cnt_q == CW'(CODE_LEN)) && !bad_q) begin
            pwd_d   = buf_q;
            state_d = S_LOCKED;
          end
        end else begin
          accept_press = 1'b1;
        end
      end
`endif
      default: state_d = S_LOCKED;
    endcase

    // Digit capture shared by code entry and reprogramming
    if (accept_press && press_ev) begin
      if (multi) begin
        invalid_d = 1'b1;
        bad_d     = 1'b1;
      end else if (cnt_q < CW'(CODE_LEN)) begin
        for (int i = 0; i < CODE_LEN; i++) begin
          if (cnt_q == CW'(i)) buf_d[i*DW +: DW] = digit;
        end
        cnt_d = cnt_q + CW'(1);
      end else begin
        bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_LOCKED;
      cnt_q    <= '0;
      fail_q   <= '0;
      timer_q  <= '0;
      buf_q    <= '0;
      pwd_q    <= PASSWORD;
      bad_q    <= 1'b0;
      prev_btn <= '0;
      invalid  <= 1'b0;
      locked   <= 1'b1;
      unlocked <= 1'b0;
      error    <= 1'b0;
      lockout  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
      buf_q    <= buf_d;
      pwd_q    <= pwd_d;
      bad_q    <= bad_d;
      prev_btn <= btn;
      invalid  <= invalid_d;
      locked   <= (state_d == S_LOCKED);
      unlocked <= (state_d == S_UNLOCKED);
      error    <= (state_d == S_ERROR);
      lockout  <= (state_d == S_LOCKOUT);
    end
  end

  assign state     = state_q;
  assign digit_cnt = cnt_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_code_lock.sv
// Self-checking bench for code_lock: behavioural model compared every cycle plus literal checkpoints.
module tb_code_lock;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       enter;
  logic       clear;
`ifdef CODE_LOCK_PROGRAM_EN
  logic       prog;
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif
  logic [2:0] state;
  logic       locked, unlocked, error, lockout, invalid;
  logic [2:0] digit_cnt;
  logic [3:0] fail_cnt;

  code_lock #(
    .NBTN(4), .CODE_LEN(4), .PASSWORD(8'h72), .MAX_TRIES(3), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .enter(enter), .clear(clear),
`ifdef CODE_LOCK_PROGRAM_EN
    .prog(prog),
`endif
    .state(state), .locked(locked), .unlocked(unlocked), .error(error), .lockout(lockout),
    .digit_cnt(digit_cnt), .fail_cnt(fail_cnt), .invalid(invalid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_cmp = 0;
  int n_miss = 0;
  bit chk_on = 1'b0;

  // Model: state code, entered digits as a queue, lockout exit as an absolute cycle number
  int         m_st;
  int         q[$];
  bit         m_bad;
  int         m_fail;
  bit         m_inv;
  logic [3:0] m_prev;
  int         m_cyc = 0;
  int         lock_exit;
  int         pw[4];

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; q.delete(); m_bad = 0; m_fail = 0; m_inv = 0; m_prev = '0;
    lock_exit = -1;
    pw[0] = 2; pw[1] = 0; pw[2] = 3; pw[3] = 1;
  endtask

  task automatic model_step(input logic [3:0] b, input bit e, input bit c, input bit p);
    bit ev, ok;
    int d;
    ev = (b != 4'd0) && (m_prev == 4'd0);
    d = 0;
    for (int i = 0; i < 4; i++) if (b[i]) d = i;
    m_inv = 0;
    m_cyc++;
    case (m_st)
      0: if (!c && e) begin m_st = 1; q.delete(); m_bad = 0; end
      1, 6: begin
        if (c) m_st = (m_st == 1) ? 0 : 4;
        else if (e) begin
          if (m_st == 1) m_st = 2;
          else if (q.size() == 4 && !m_bad) begin
            for (int i = 0; i < 4; i++) pw[i] = q[i];
            m_st = 0;
          end else m_st = 4;
        end else if (ev) begin
          if ($countones(b) > 1) begin m_inv = 1; m_bad = 1; end
          else if (q.size() < 4) q.push_back(d);
          else m_bad = 1;
        end
      end
      2: begin
        ok = (q.size() == 4) && !m_bad;
        if (ok) for (int i = 0; i < 4; i++) if (q[i] != pw[i]) ok = 0;
        if (ok) begin m_st = 4; m_fail = 0; end
        else begin
          m_fail++;
          if (m_fail == 3) begin m_st = 5; lock_exit = m_cyc + 16; end
          else m_st = 3;
        end
      end
      3: if (c) m_st = 0;
      4: begin
        if (c) m_st = 0;
        else if (p && PROG_EN) begin m_st = 6; q.delete(); m_bad = 0; end
      end
      5: if (m_cyc == lock_exit) begin m_st = 0; m_fail = 0; end
      default: m_st = 0;
    endcase
    m_prev = b;
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("state", int'(state), m_st);
      cmp("locked", int'(locked), int'(m_st == 0));
      cmp("unlocked", int'(unlocked), int'(m_st == 4));
      cmp("error", int'(error), int'(m_st == 3));
      cmp("lockout", int'(lockout), int'(m_st == 5));
      cmp("digit_cnt", int'(digit_cnt), q.size());
      cmp("fail_cnt", int'(fail_cnt), m_fail);
      cmp("invalid", int'(invalid), int'(m_inv));
    end
  end

  task automatic apply(input logic [3:0] b, input bit e, input bit c, input bit p);
    btn = b; enter = e; clear = c;
`ifdef CODE_LOCK_PROGRAM_EN
    prog = p;
`endif
    @(posedge clk);
    model_step(b, e, c, p);
    n_vec++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input int d);
    apply(4'(1 << d), 1'b0, 1'b0, 1'b0);
    apply(4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Digits packed one per nibble, digit 0 lowest; leaves the lock in the verify result
  task automatic try_code(input logic [31:0] ds, input int n);
    apply(4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) press(int'(ds[i*4 +: 4]));
    apply(4'd0, 1'b1, 1'b0, 1'b0);
    cmp("verify_state", int'(state), 2);
    idle(1);
  endtask

  task automatic do_clear();
    apply(4'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b0; btn = '0; enter = 1'b0; clear = 1'b0;
`ifdef CODE_LOCK_PROGRAM_EN
    prog = 1'b0;
`endif
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    chk_on = 1'b1;
    cmp("reset_state", int'(state), 0);
    cmp("reset_locked", int'(locked), 1);
    cmp("reset_fail", int'(fail_cnt), 0);

    // Correct code 2,0,3,1
    try_code(32'h1302, 4);
    cmp("good_state", int'(state), 4);
    cmp("good_unlocked", int'(unlocked), 1);
    cmp("good_fail", int'(fail_cnt), 0);
    do_clear();
    cmp("relock_state", int'(state), 0);

    // Too few digits, then overflow
    try_code(32'h302, 3);
    cmp("short_state", int'(state), 3);
    cmp("short_fail", int'(fail_cnt), 1);
    do_clear();
    try_code(32'h11302, 5);
    cmp("overflow_state", int'(state), 3);
    cmp("overflow_fail", int'(fail_cnt), 2);
    do_clear();
    try_code(32'h1302, 4);
    cmp("recover_fail", int'(fail_cnt), 0);
    do_clear();

    // Multi-button press poisons the attempt
    apply(4'd0, 1'b1, 1'b0, 1'b0);
    apply(4'b0101, 1'b0, 1'b0, 1'b0);
    cmp("invalid_pulse", int'(invalid), 1);
    cmp("invalid_cnt", int'(digit_cnt), 0);
    apply(4'd0, 1'b0, 1'b0, 1'b0);
    cmp("invalid_drop", int'(invalid), 0);
    for (int i = 0; i < 4; i++) press(int'(i == 0 ? 2 : i == 1 ? 0 : i == 2 ? 3 : 1));
    apply(4'd0, 1'b1, 1'b0, 1'b0);
    idle(1);
    cmp("invalid_result", int'(state), 3);
    do_clear();

    // Held button yields one digit; clear beats enter
    apply(4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) apply(4'b0100, 1'b0, 1'b0, 1'b0);
    apply(4'd0, 1'b0, 1'b0, 1'b0);
    cmp("held_cnt", int'(digit_cnt), 1);
    apply(4'd0, 1'b1, 1'b1, 1'b0);
    cmp("clear_prio", int'(state), 0);

    // Clear the failure from the poisoned attempt, then three wrong codes
    try_code(32'h1302, 4);
    do_clear();
    for (int k = 0; k < 2; k++) begin
      try_code(32'h1111, 4);
      do_clear();
    end
    try_code(32'h1111, 4);
    cmp("lockout_state", int'(state), 5);
    cmp("lockout_flag", int'(lockout), 1);
    for (int i = 0; i < 15; i++) apply(4'(1 << (i % 4)), i[0], i[1], 1'b0);
    cmp("lockout_hold", int'(state), 5);
    idle(1);
    cmp("lockout_exit", int'(state), 0);
    cmp("lockout_fail", int'(fail_cnt), 0);

    // Reset in the middle of a lockout
    for (int k = 0; k < 2; k++) begin
      try_code(32'h2222, 4);
      do_clear();
    end
    try_code(32'h2222, 4);
    idle(3);
    reset = 1'b0;
    #1;
    model_reset();
    cmp("async_state", int'(state), 0);
    cmp("async_lockout", int'(lockout), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    idle(2);
    cmp("post_reset_state", int'(state), 0);
    try_code(32'h1302, 4);
    cmp("post_reset_unlock", int'(state), 4);
    do_clear();

`ifdef CODE_LOCK_PROGRAM_EN
    // Reprogram to 1,1,2,2
    try_code(32'h1302, 4);
    apply(4'd0, 1'b0, 1'b0, 1'b1);
    cmp("prog_state", int'(state), 6);
    apply(4'd0, 1'b0, 1'b0, 1'b0);
    press(1); press(1); press(2); press(2);
    apply(4'd0, 1'b1, 1'b0, 1'b0);
    cmp("prog_done", int'(state), 0);
    try_code(32'h1302, 4);
    cmp("old_code", int'(state), 3);
    do_clear();
    try_code(32'h2211, 4);
    cmp("new_code", int'(state), 4);
    do_clear();
`endif

    idle(2);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
